// File: rtl/vga_timing_stream_if.sv
// rtl/vga_timing_stream_if.sv - pixel stream handshake between frame-buffer reader and timing generator
interface vga_timing_stream_if #(
   parameter int CW = 8
);
   logic [3*CW-1:0] pix_data;
   logic            pix_valid;
   logic            pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_timing_stream.sv
// rtl/vga_timing_stream.sv - parametrised VGA timing generator pulling RGB pixels from a stream
// Optional test patterns are built only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_stream #(
   parameter int HDISP  = 640,
   parameter int HFP    = 16,
   parameter int HPULSE = 96,
   parameter int HBP    = 48,
   parameter int VDISP  = 480,
   parameter int VFP    = 11,
   parameter int VPULSE = 2,
   parameter int VBP    = 31,
   parameter int HS_POL = 0,
   parameter int VS_POL = 0,
   parameter int CW     = 8,
   localparam int HTOT  = HDISP + HFP + HPULSE + HBP,
   localparam int VTOT  = VDISP + VFP + VPULSE + VBP,
   localparam int XW    = $clog2(HTOT),
   localparam int YW    = $clog2(VTOT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_enable,
   vga_timing_stream_if.slave      pix_s,
   input  logic                    i_underflow_clr,
   input  logic [1:0]              i_pattern_sel,
   output logic [XW-1:0]           o_x,
   output logic [YW-1:0]           o_y,
   output logic                    o_frame_start,
   output logic                    o_line_start,
   output logic                    o_vga_hs,
   output logic                    o_vga_vs,
   output logic                    o_vga_blank_n,
   output logic [CW-1:0]           o_vga_r,
   output logic [CW-1:0]           o_vga_g,
   output logic [CW-1:0]           o_vga_b,
   output logic                    o_underflow
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   state_t             r_state;
   logic [XW-1:0]      r_h;
   logic [YW-1:0]      r_v;
   logic               r_hs;
   logic               r_vs;
   logic               r_blank_n;
   logic [3*CW-1:0]    r_rgb;
   logic               r_underflow;
   logic               r_frame_start;
   logic               r_line_start;

   logic               w_h_last;
   logic               w_v_last;
   logic               w_frame_end;
   logic               w_active;
   logic               w_hs_zone;
   logic               w_vs_zone;
   logic               w_ready;
   logic               w_xfer;
   logic               w_pat_on;
   logic [3*CW-1:0]    w_pat_rgb;

   assign w_h_last    = (r_h == XW'(HTOT - 1));
   assign w_v_last    = (r_v == YW'(VTOT - 1));
   assign w_frame_end = w_h_last && w_v_last;
   assign w_active    = (r_h < XW'(HDISP)) && (r_v < YW'(VDISP)) && (r_state != S_IDLE);
   assign w_hs_zone   = (r_h >= XW'(HDISP + HFP)) && (r_h < XW'(HDISP + HFP + HPULSE));
   assign w_vs_zone   = (r_v >= YW'(VDISP + VFP)) && (r_v < YW'(VDISP + VFP + VPULSE));

`ifdef VGA_TEST_PATTERN_EN
   logic [CW+XW+3:0]   w_hx;
   logic [CW+YW+3:0]   w_vx;

   // Zero-extended copies so narrow counters can still feed 4-bit grid and CW-bit ramps.
   assign w_hx     = {{(CW+4){1'b0}}, r_h};
   assign w_vx     = {{(CW+4){1'b0}}, r_v};
   assign w_pat_on = (i_pattern_sel != 2'd0);

   always_comb begin
      w_pat_rgb = '0;
      case (i_pattern_sel)
         2'd1: if ((w_hx[3:0] == 4'd0) || (w_vx[3:0] == 4'd0)) w_pat_rgb = '1;
         2'd2: w_pat_rgb = {w_hx[CW-1:0], w_vx[CW-1:0], {CW{1'b0}}};
         2'd3: w_pat_rgb = '1;
         default: w_pat_rgb = '0;
      endcase
   end
`else
   logic w_unused_pattern_sel;

   assign w_unused_pattern_sel = ^i_pattern_sel;
   assign w_pat_on             = 1'b0;
   assign w_pat_rgb            = '0;
`endif

   assign w_ready         = w_active && !w_pat_on;
   assign w_xfer          = w_ready && pix_s.pix_valid;
   assign pix_s.pix_ready = w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_h           <= '0;
         r_v           <= '0;
         r_hs          <= ~HS_ACT;
         r_vs          <= ~VS_ACT;
         r_blank_n     <= 1'b0;
         r_rgb         <= '0;
         r_underflow   <= 1'b0;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_h <= '0;
               r_v <= '0;
               if (i_enable) r_state <= S_RUN;
            end
            default: begin
               // A drop of enable only stops the timing once the frame has fully drained.
               if (w_frame_end && !i_enable) begin
                  r_state <= S_IDLE;
                  r_h     <= '0;
                  r_v     <= '0;
               end else begin
                  r_state <= i_enable ? S_RUN : S_DRAIN;
                  if (w_h_last) begin
                     r_h <= '0;
                     r_v <= w_v_last ? '0 : r_v + YW'(1);
                  end else begin
                     r_h <= r_h + XW'(1);
                  end
               end
            end
         endcase

         r_hs          <= ((r_state != S_IDLE) && w_hs_zone) ? HS_ACT : ~HS_ACT;
         r_vs          <= ((r_state != S_IDLE) && w_vs_zone) ? VS_ACT : ~VS_ACT;
         r_blank_n     <= w_active;
         r_frame_start <= (r_state == S_RUN) && (r_h == '0) && (r_v == '0);
         r_line_start  <= (r_state != S_IDLE) && (r_h == '0) && (r_v < YW'(VDISP));

         if (w_pat_on)
            r_rgb <= w_active ? w_pat_rgb : '0;
         else
            r_rgb <= w_xfer ? pix_s.pix_data : '0;

         // Set has priority over a clear arriving in the same cycle.
         if (!w_pat_on) begin
            if (w_active && !pix_s.pix_valid)
               r_underflow <= 1'b1;
            else if (i_underflow_clr)
               r_underflow <= 1'b0;
         end
      end
   end

   assign o_x           = r_h;
   assign o_y           = r_v;
   assign o_frame_start = r_frame_start;
   assign o_line_start  = r_line_start;
   assign o_vga_hs      = r_hs;
   assign o_vga_vs      = r_vs;
   assign o_vga_blank_n = r_blank_n;
   assign o_vga_r       = r_rgb[3*CW-1:2*CW];
   assign o_vga_g       = r_rgb[2*CW-1:CW];
   assign o_vga_b       = r_rgb[CW-1:0];
   assign o_underflow   = r_underflow;
endmodule

// File: tb/tb_vga_timing_stream.sv
// tb/tb_vga_timing_stream.sv - directed bench for vga_timing_stream on a 14x8 mode
module tb_vga_timing_stream;
   localparam int CW = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_enable = 1'b0;
   logic       i_underflow_clr = 1'b0;
   logic [1:0] i_pattern_sel = 2'd0;
   logic [3:0] o_x;
   logic [2:0] o_y;
   logic       o_frame_start, o_line_start, o_vga_hs, o_vga_vs, o_vga_blank_n, o_underflow;
   logic [7:0] o_vga_r, o_vga_g, o_vga_b;

   int n_chk = 0;
   int n_err = 0;
   int ch = 0, cv = 0, ph = -1, pv = -1;

   vga_timing_stream_if #(.CW(CW)) pix ();

   vga_timing_stream #(
      .HDISP(8), .HFP(2), .HPULSE(3), .HBP(1),
      .VDISP(4), .VFP(1), .VPULSE(2), .VBP(1),
      .HS_POL(0), .VS_POL(0), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable), .pix_s(pix.slave),
      .i_underflow_clr(i_underflow_clr), .i_pattern_sel(i_pattern_sel),
      .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start), .o_line_start(o_line_start),
      .o_vga_hs(o_vga_hs), .o_vga_vs(o_vga_vs), .o_vga_blank_n(o_vga_blank_n),
      .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b), .o_underflow(o_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         h;
      int         v;
      logic       hs;
      logic       vs;
      logic       bn;
      logic [23:0] rgb;
      logic       fs;
      logic       ls;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [23:0] mk(int h, int v);
      return {8'(h), 8'(v), 8'h5A};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      ph = ch;
      pv = cv;
      if (ch == 13) begin
         ch = 0;
         cv = (cv == 7) ? 0 : cv + 1;
      end else begin
         ch++;
      end
      @(negedge clk);
      pix.pix_data = mk(ch, cv);
   endtask

   task automatic tick_first();
      @(posedge clk);
      @(negedge clk);
      ch = 0; cv = 0; ph = -1; pv = -1;
      pix.pix_data = mk(0, 0);
   endtask

   task automatic to_pins(int h, int v);
      int n = 0;
      while (!(ph == h && pv == v) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("timeout_pins", 32'(n), 32'd0);
   endtask

   task automatic to_cnt(int h, int v);
      int n = 0;
      while (!(ch == h && cv == v) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("timeout_cnt", 32'(n), 32'd0);
   endtask

   initial begin
      int n_rdy;
      int n_fs;
      tbl[0]  = '{0,  0, 1, 1, 1, 24'h00005A, 1, 1};
      tbl[1]  = '{7,  0, 1, 1, 1, 24'h07005A, 0, 0};
      tbl[2]  = '{8,  0, 1, 1, 0, 24'h0,      0, 0};
      tbl[3]  = '{9,  0, 1, 1, 0, 24'h0,      0, 0};
      tbl[4]  = '{10, 0, 0, 1, 0, 24'h0,      0, 0};
      tbl[5]  = '{12, 0, 0, 1, 0, 24'h0,      0, 0};
      tbl[6]  = '{13, 0, 1, 1, 0, 24'h0,      0, 0};
      tbl[7]  = '{0,  1, 1, 1, 1, 24'h00015A, 0, 1};
      tbl[8]  = '{3,  2, 1, 1, 1, 24'h03025A, 0, 0};
      tbl[9]  = '{0,  4, 1, 1, 0, 24'h0,      0, 0};
      tbl[10] = '{4,  5, 1, 0, 0, 24'h0,      0, 0};
      tbl[11] = '{11, 6, 0, 0, 0, 24'h0,      0, 0};
      tbl[12] = '{0,  7, 1, 1, 0, 24'h0,      0, 0};
      tbl[13] = '{0,  0, 1, 1, 1, 24'h00005A, 1, 1};

      pix.pix_data  = '0;
      pix.pix_valid = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_hs", 32'(o_vga_hs), 32'd1);
      chk("rst_vs", 32'(o_vga_vs), 32'd1);
      chk("rst_blank", 32'(o_vga_blank_n), 32'd0);
      chk("rst_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, 32'd0);
      chk("rst_ready", 32'(pix.pix_ready), 32'd0);
      chk("rst_uf", 32'(o_underflow), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_x", 32'(o_x), 32'd0);
      chk("idle_fs", 32'(o_frame_start), 32'd0);

      // timing table over the first frame
      i_enable = 1'b1;
      pix.pix_data = mk(0, 0);
      tick_first();
      for (int i = 0; i < 14; i++) begin
         to_pins(tbl[i].h, tbl[i].v);
         chk($sformatf("t%0d_hs", i), 32'(o_vga_hs), 32'(tbl[i].hs));
         chk($sformatf("t%0d_vs", i), 32'(o_vga_vs), 32'(tbl[i].vs));
         chk($sformatf("t%0d_blank", i), 32'(o_vga_blank_n), 32'(tbl[i].bn));
         chk($sformatf("t%0d_rgb", i), {8'd0, o_vga_r, o_vga_g, o_vga_b}, {8'd0, tbl[i].rgb});
         chk($sformatf("t%0d_fs", i), 32'(o_frame_start), 32'(tbl[i].fs));
         chk($sformatf("t%0d_ls", i), 32'(o_line_start), 32'(tbl[i].ls));
         chk($sformatf("t%0d_x", i), 32'(o_x), (tbl[i].h == 13) ? 32'd0 : 32'(tbl[i].h + 1));
      end

      // one full frame: transfers and frame_start pulses
      n_rdy = 0;
      n_fs  = 0;
      for (int i = 0; i < 112; i++) begin
         tick();
         if (pix.pix_ready && pix.pix_valid) n_rdy++;
         if (o_frame_start) n_fs++;
      end
      chk("xfer_per_frame", 32'(n_rdy), 32'd32);
      chk("fs_per_frame", 32'(n_fs), 32'd1);

      // single missing pixel
      to_cnt(3, 2);
      pix.pix_valid = 1'b0;
      chk("uf_ready", 32'(pix.pix_ready), 32'd1);
      tick();
      pix.pix_valid = 1'b1;
      chk("uf_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, 32'd0);
      chk("uf_blank", 32'(o_vga_blank_n), 32'd1);
      chk("uf_set", 32'(o_underflow), 32'd1);
      to_cnt(10, 2);
      chk("uf_held", 32'(o_underflow), 32'd1);
      i_underflow_clr = 1'b1;
      tick();
      i_underflow_clr = 1'b0;
      chk("uf_clr", 32'(o_underflow), 32'd0);

      // clear collides with a new underflow
      to_cnt(5, 3);
      pix.pix_valid = 1'b0;
      i_underflow_clr = 1'b1;
      tick();
      pix.pix_valid = 1'b1;
      i_underflow_clr = 1'b0;
      chk("uf_set_wins", 32'(o_underflow), 32'd1);
      i_underflow_clr = 1'b1;
      tick();
      i_underflow_clr = 1'b0;
      chk("uf_clr2", 32'(o_underflow), 32'd0);

      // enable dropped mid-frame: frame drains, then idle
      to_cnt(5, 1);
      i_enable = 1'b0;
      to_pins(2, 2);
      chk("drain_blank", 32'(o_vga_blank_n), 32'd1);
      chk("drain_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, {8'd0, mk(2, 2)});
      to_pins(13, 7);
      chk("drain_end_hs", 32'(o_vga_hs), 32'd1);
      chk("drain_end_vs", 32'(o_vga_vs), 32'd1);
      n_fs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_frame_start || o_vga_blank_n || o_x != 4'd0) n_fs++;
      end
      chk("idle_quiet", 32'(n_fs), 32'd0);
      chk("idle_ready", 32'(pix.pix_ready), 32'd0);
      chk("idle_hs", 32'(o_vga_hs), 32'd1);
      chk("idle_vs", 32'(o_vga_vs), 32'd1);
      chk("idle_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, 32'd0);

      // asynchronous reset mid-line
      i_enable = 1'b1;
      tick_first();
      pix.pix_valid = 1'b0;
      tick();
      pix.pix_valid = 1'b1;
      to_pins(3, 1);
      chk("pre_rst_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, {8'd0, mk(3, 1)});
      chk("pre_rst_uf", 32'(o_underflow), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_blank", 32'(o_vga_blank_n), 32'd0);
      chk("arst_rgb", {8'd0, o_vga_r, o_vga_g, o_vga_b}, 32'd0);
      chk("arst_x", 32'(o_x), 32'd0);
      chk("arst_y", 32'(o_y), 32'd0);
      chk("arst_ready", 32'(pix.pix_ready), 32'd0);
      chk("arst_uf", 32'(o_underflow), 32'd0);
      chk("arst_hs", 32'(o_vga_hs), 32'd1);
      chk("arst_ls", 32'(o_line_start), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
